// File: rtl/free_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : free_buffer_arbiter
//  Description : Shares one preloaded free-buffer ID pool between NUM_PORTS
//                tasks. Two independent round-robin arbiters: allocation
//                requests against the pool read side, and returned IDs
//                against the pool write side. Tracks outstanding IDs and
//                flags over-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module free_buffer_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 8,
    parameter int POOL_SIZE  = 16,
    localparam int CNT_WIDTH = $clog2(POOL_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          alloc_req,
    output logic [NUM_PORTS-1:0]          alloc_gnt,
    output logic [ID_WIDTH-1:0]           alloc_id,
    input  logic [NUM_PORTS-1:0]          free_valid,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] free_id,
    output logic [NUM_PORTS-1:0]          free_ready,
    input  logic                          pool_empty_n,
    output logic                          pool_read,
    input  logic [ID_WIDTH-1:0]           pool_dout,
    input  logic                          pool_full_n,
    output logic                          pool_write,
    output logic [ID_WIDTH-1:0]           pool_din,
    output logic [CNT_WIDTH-1:0]          outstanding,
    output logic                          err_overfree
);

    localparam int                   PTR_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = CNT_WIDTH'(POOL_SIZE);
    localparam logic [PTR_WIDTH-1:0] C_PTR_LAST = PTR_WIDTH'(NUM_PORTS - 1);

    // First requesting port at or after ptr, wrapping around the port range.
    function automatic logic [PTR_WIDTH-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [PTR_WIDTH-1:0] ptr
    );
        logic [PTR_WIDTH-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req[idx]) begin
                pick  = PTR_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Pointer to the port after the winner, wrapping to port 0.
    function automatic logic [PTR_WIDTH-1:0] ptr_after(input logic [PTR_WIDTH-1:0] win);
        return (win == C_PTR_LAST) ? '0 : win + PTR_WIDTH'(1);
    endfunction

    logic [PTR_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_WIDTH-1:0] free_ptr_q, free_ptr_d;
    logic [NUM_PORTS-1:0] alloc_gnt_q, alloc_gnt_d;
    logic [ID_WIDTH-1:0]  alloc_id_q, alloc_id_d;
    logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic                 err_overfree_q, err_overfree_d;

    logic [PTR_WIDTH-1:0] w_alloc_win;
    logic [PTR_WIDTH-1:0] w_free_win;
    logic                 w_alloc_fire;
    logic                 w_free_fire;
    logic                 w_overfree;

    assign w_alloc_win  = rr_pick(alloc_req, alloc_ptr_q);
    assign w_free_win   = rr_pick(free_valid, free_ptr_q);

    // Both arbiters are held off while reset is asserted.
    assign w_alloc_fire = reset_n & pool_empty_n & (|alloc_req);
    assign w_free_fire  = reset_n & pool_full_n & (|free_valid);

    // A release with nothing outstanding (and no pop this cycle to balance
    // it) is accepted so the releaser is not stuck, but its ID is dropped.
    assign w_overfree   = w_free_fire & (outstanding_q == '0) & ~w_alloc_fire;

    assign pool_read    = w_alloc_fire;
    assign pool_write   = w_free_fire & ~w_overfree;
    assign pool_din     = free_id[w_free_win*ID_WIDTH +: ID_WIDTH];
    assign free_ready   = w_free_fire ? (NUM_PORTS'(1) << w_free_win) : '0;

    assign alloc_gnt    = alloc_gnt_q;
    assign alloc_id     = alloc_id_q;
    assign outstanding  = outstanding_q;
    assign err_overfree = err_overfree_q;

    // Allocation arbiter: register the one-hot grant and the popped pool head.
    always_comb begin
        alloc_gnt_d = '0;
        alloc_id_d  = alloc_id_q;
        alloc_ptr_d = alloc_ptr_q;
        if (w_alloc_fire) begin
            alloc_gnt_d = NUM_PORTS'(1) << w_alloc_win;
            alloc_id_d  = pool_dout;
            alloc_ptr_d = ptr_after(w_alloc_win);
        end
    end

    // Free arbiter: advance the pointer past every accepted release.
    always_comb begin
        free_ptr_d = free_ptr_q;
        if (w_free_fire) begin
            free_ptr_d = ptr_after(w_free_win);
        end
    end

    // Outstanding counter (+pop, -returned ID, saturating) and sticky error.
    always_comb begin
        outstanding_d  = outstanding_q;
        err_overfree_d = err_overfree_q | w_overfree;
        case ({pool_read, pool_write})
            2'b10: begin
                if (outstanding_q != C_CNT_MAX) begin
                    outstanding_d = outstanding_q + CNT_WIDTH'(1);
                end
            end
            2'b01: begin
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - CNT_WIDTH'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_ptr_q    <= '0;
            free_ptr_q     <= '0;
            alloc_gnt_q    <= '0;
            alloc_id_q     <= '0;
            outstanding_q  <= '0;
            err_overfree_q <= 1'b0;
        end else begin
            alloc_ptr_q    <= alloc_ptr_d;
            free_ptr_q     <= free_ptr_d;
            alloc_gnt_q    <= alloc_gnt_d;
            alloc_id_q     <= alloc_id_d;
            outstanding_q  <= outstanding_d;
            err_overfree_q <= err_overfree_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_free_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_free_buffer_arbiter
//  Description : Self-checking bench for free_buffer_arbiter: directed vector
//                table, multi-cycle corner sequences and random traffic
//                against a queue-based pool and reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_free_buffer_arbiter;

    localparam int NP = 4;
    localparam int IW = 8;
    localparam int PS = 16;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP-1:0]     alloc_req = '0;
    logic [NP-1:0]     alloc_gnt;
    logic [IW-1:0]     alloc_id;
    logic [NP-1:0]     free_valid = '0;
    logic [NP*IW-1:0]  free_id = '0;
    logic [NP-1:0]     free_ready;
    logic              pool_empty_n;
    logic              pool_read;
    logic [IW-1:0]     pool_dout;
    logic              pool_full_n;
    logic              pool_write;
    logic [IW-1:0]     pool_din;
    logic [CW-1:0]     outstanding;
    logic              err_overfree;

    always #5 clk = ~clk;

    free_buffer_arbiter #(.NUM_PORTS(NP), .ID_WIDTH(IW), .POOL_SIZE(PS)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .free_valid(free_valid), .free_id(free_id), .free_ready(free_ready),
        .pool_empty_n(pool_empty_n), .pool_read(pool_read), .pool_dout(pool_dout),
        .pool_full_n(pool_full_n), .pool_write(pool_write), .pool_din(pool_din),
        .outstanding(outstanding), .err_overfree(err_overfree)
    );

    int total = 0;
    int bad   = 0;

    // Pool FIFO model (FWFT), with overrides to force empty/full flags.
    int pool_q[$];
    bit f_empty = 1'b0;
    bit f_full  = 1'b0;

    // Reference model state
    int            m_aptr, m_fptr, m_out;
    bit            m_err;
    logic [NP-1:0] m_gnt;
    logic [IW-1:0] m_id;

    // Values seen on the combinational outputs in the last step
    logic          c_read, c_write;
    logic [NP-1:0] c_ready;
    logic [IW-1:0] c_din;

    int held[$];

    typedef struct {
        logic          rst;
        logic [NP-1:0] req;
        logic [NP-1:0] fv;
        logic [IW-1:0] fid;
        logic          fe;
        logic          ff;
        logic          e_read;
        logic [NP-1:0] e_rdy;
        logic          e_wr;
        logic [NP-1:0] e_gnt;
        logic [IW-1:0] e_id;
        logic [CW-1:0] e_out;
        logic          e_err;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pool_drive();
        pool_empty_n = (pool_q.size() != 0) && !f_empty;
        pool_full_n  = (pool_q.size() < 32) && !f_full;
        pool_dout    = (pool_q.size() != 0) ? IW'(pool_q[0]) : '0;
    endtask

    task automatic pool_reset();
        pool_q.delete();
        for (int i = 0; i < PS; i++) pool_q.push_back(i);
        pool_drive();
    endtask

    task automatic model_reset();
        m_aptr = 0; m_fptr = 0; m_out = 0; m_err = 1'b0;
        m_gnt = '0; m_id = '0;
    endtask

    // One clock cycle: predict and check combinational outputs before the
    // edge, then update pool and model and check registered outputs after.
    task automatic step();
        logic          e_read, e_write;
        logic [NP-1:0] e_ready, n_gnt;
        logic [IW-1:0] e_din, n_id;
        int            n_aptr, n_fptr, n_out, p;
        bit            n_err, found;
        @(negedge clk);
        e_read = pool_empty_n && (alloc_req != '0);
        n_gnt = '0; n_id = m_id; n_aptr = m_aptr; n_fptr = m_fptr; n_err = m_err;
        if (e_read) begin
            found = 1'b0;
            for (int d = 0; d < NP; d++) begin
                p = (m_aptr + d) % NP;
                if (!found && alloc_req[p]) begin
                    found = 1'b1; n_gnt = NP'(1 << p); n_aptr = (p + 1) % NP;
                end
            end
            n_id = pool_dout;
        end
        e_ready = '0; e_write = 1'b0; e_din = '0;
        if (pool_full_n && (free_valid != '0)) begin
            found = 1'b0;
            for (int d = 0; d < NP; d++) begin
                p = (m_fptr + d) % NP;
                if (!found && free_valid[p]) begin
                    found = 1'b1; e_ready = NP'(1 << p); n_fptr = (p + 1) % NP;
                    if (m_out == 0 && !e_read) n_err = 1'b1;
                    else begin e_write = 1'b1; e_din = free_id[p*IW +: IW]; end
                end
            end
        end
        n_out = m_out + (e_read ? 1 : 0) - (e_write ? 1 : 0);
        if (n_out > PS) n_out = PS;
        chk("pool_read", 32'(pool_read), 32'(e_read));
        chk("free_ready", 32'(free_ready), 32'(e_ready));
        chk("pool_write", 32'(pool_write), 32'(e_write));
        if (e_write) chk("pool_din", 32'(pool_din), 32'(e_din));
        c_read = pool_read; c_write = pool_write; c_ready = free_ready; c_din = pool_din;
        @(posedge clk);
        #1;
        if (c_read && pool_q.size() > 0) void'(pool_q.pop_front());
        if (c_write) pool_q.push_back(int'(c_din));
        pool_drive();
        m_aptr = n_aptr; m_fptr = n_fptr; m_out = n_out; m_err = n_err;
        m_gnt = n_gnt; m_id = n_id;
        chk("alloc_gnt", 32'(alloc_gnt), 32'(m_gnt));
        chk("outstanding", 32'(outstanding), 32'(m_out));
        chk("err_overfree", 32'(err_overfree), 32'(m_err));
        if (m_gnt != '0) chk("alloc_id", 32'(alloc_id), 32'(m_id));
    endtask

    // Reset with all requests asserted so the output gating is exercised.
    task automatic do_reset();
        reset_n = 1'b0;
        alloc_req = '1; free_valid = '1;
        f_empty = 1'b0; f_full = 1'b0;
        model_reset();
        pool_reset();
        #1;
        chk("rst_gnt", 32'(alloc_gnt), 32'h0);
        chk("rst_id", 32'(alloc_id), 32'h0);
        chk("rst_out", 32'(outstanding), 32'h0);
        chk("rst_err", 32'(err_overfree), 32'h0);
        chk("rst_read", 32'(pool_read), 32'h0);
        chk("rst_write", 32'(pool_write), 32'h0);
        chk("rst_ready", 32'(free_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        alloc_req = '0; free_valid = '0;
        reset_n = 1'b1;
    endtask

    task automatic set_fid(input logic [IW-1:0] v);
        for (int p = 0; p < NP; p++) free_id[p*IW +: IW] = v;
    endtask

    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            alloc_req = tbl[i].req; free_valid = tbl[i].fv; set_fid(tbl[i].fid);
            f_empty = tbl[i].fe; f_full = tbl[i].ff;
            pool_drive();
            step();
            chk($sformatf("tbl%0d_read", i), 32'(c_read), 32'(tbl[i].e_read));
            chk($sformatf("tbl%0d_ready", i), 32'(c_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_write", i), 32'(c_write), 32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_gnt", i), 32'(alloc_gnt), 32'(tbl[i].e_gnt));
            if (tbl[i].e_gnt != '0) chk($sformatf("tbl%0d_id", i), 32'(alloc_id), 32'(tbl[i].e_id));
            chk($sformatf("tbl%0d_out", i), 32'(outstanding), 32'(tbl[i].e_out));
            chk($sformatf("tbl%0d_err", i), 32'(err_overfree), 32'(tbl[i].e_err));
        end
        f_empty = 1'b0; f_full = 1'b0; alloc_req = '0; free_valid = '0;
        pool_drive();
    endtask

    // Drain the pool, hold requests while empty, then return ID 7.
    task automatic run_drain();
        do_reset();
        alloc_req = '1;
        for (int i = 0; i < 40 && m_out < PS; i++) step();
        chk("drain_out", 32'(outstanding), 32'(PS));
        chk("drain_empty_n", 32'(pool_empty_n), 32'h0);
        step();
        chk("empty_no_read", 32'(c_read), 32'h0);
        chk("empty_no_gnt", 32'(alloc_gnt), 32'h0);
        free_valid = 4'b0010; free_id[1*IW +: IW] = 8'd7;
        step();
        chk("ret7_ready", 32'(c_ready), 32'h2);
        chk("ret7_write", 32'(c_write), 32'h1);
        chk("ret7_din", 32'(c_din), 32'h7);
        free_valid = '0;
        step();
        chk("ret7_gnt", 32'(alloc_gnt), 32'h1);
        chk("ret7_id", 32'(alloc_id), 32'h7);
        alloc_req = '0;
        step();
    endtask

    // Reset arriving between a request and its grant.
    task automatic run_reset_mid();
        do_reset();
        alloc_req = 4'b0001;
        step();
        chk("mid_first_gnt", 32'(alloc_gnt), 32'h1);
        alloc_req = 4'b0100;
        @(negedge clk);
        chk("mid_read_before", 32'(pool_read), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_async_gnt", 32'(alloc_gnt), 32'h0);
        chk("mid_async_out", 32'(outstanding), 32'h0);
        chk("mid_async_read", 32'(pool_read), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_no_gnt", 32'(alloc_gnt), 32'h0);
        model_reset();
        pool_reset();
        alloc_req = '1;
        reset_n = 1'b1;
        step();
        chk("mid_restart_gnt", 32'(alloc_gnt), 32'h1);
        chk("mid_restart_id", 32'(alloc_id), 32'h0);
        alloc_req = '0;
        step();
    endtask

    // Protocol-respecting random requesters and releasers.
    task automatic run_random(input int cycles);
        int            k;
        logic [NP-1:0] l_ready;
        do_reset();
        held.delete();
        l_ready = '0;
        for (int c = 0; c < cycles; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (alloc_req[p] && m_gnt[p]) alloc_req[p] = 1'b0;
                else if (!alloc_req[p] && $urandom_range(0, 3) == 0) alloc_req[p] = 1'b1;
                if (free_valid[p] && l_ready[p]) free_valid[p] = 1'b0;
                else if (!free_valid[p] && $urandom_range(0, 4) == 0) begin
                    if (held.size() > 0) begin
                        k = $urandom_range(0, held.size() - 1);
                        free_id[p*IW +: IW] = IW'(held[k]);
                        held.delete(k);
                        free_valid[p] = 1'b1;
                    end else if ($urandom_range(0, 15) == 0) begin
                        free_id[p*IW +: IW] = IW'($urandom_range(0, 15));
                        free_valid[p] = 1'b1;
                    end
                end
            end
            f_full  = ($urandom_range(0, 9) == 0);
            f_empty = ($urandom_range(0, 9) == 0);
            pool_drive();
            step();
            if (m_gnt != '0) held.push_back(int'(m_id));
            l_ready = c_ready;
        end
        alloc_req = '0; free_valid = '0; f_full = 1'b0; f_empty = 1'b0;
        pool_drive();
    endtask

    initial begin
        //         rst   req      fv       fid    fe    ff    rd    rdy      wr    gnt      id     out    err
        tbl[0]  = '{1'b1, 4'b0100, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'd0, 5'd1, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd0, 5'd1, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 8'd0, 5'd1, 1'b0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0010, 8'd1, 5'd2, 1'b0};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'd2, 5'd3, 1'b0};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 8'd3, 5'd4, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 8'd4, 5'd5, 1'b0};
        tbl[7]  = '{1'b0, 4'b0001, 4'b1000, 8'd2, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 4'b0001, 8'd5, 5'd5, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0010, 8'd7, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd0, 5'd5, 1'b0};
        tbl[9]  = '{1'b0, 4'b0010, 4'b0100, 8'd3, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 8'd0, 5'd4, 1'b0};
        tbl[10] = '{1'b1, 4'b0000, 4'b0010, 8'd5, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000, 8'd0, 5'd0, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'd0, 5'd0, 1'b1};
        tbl[12] = '{1'b0, 4'b0001, 4'b0100, 8'd9, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0001, 8'd0, 5'd0, 1'b1};

        model_reset();
        pool_reset();
        @(posedge clk);
        #1;
        run_table();
        run_drain();
        run_reset_mid();
        run_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
